fft8_frame_loader: RTL and testbench

- Double-buffered input framer directly upstream of the 8-point FFT core.
- Accepts a serial stream of signed 16-bit real samples over a valid/ready handshake and groups them into 8-sample frames in natural order.
- Presents each complete frame on eight parallel sample outputs, which feed the FFT's eight real inputs, with a valid/ready frame handshake.
- Ping-pong banking lets one frame be filled while the previous one is held for the FFT.

---
 rtl/fft8_frame_loader.sv | 162 ++++++++++++++++
 tb/tb_fft8_frame_loader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft8_frame_loader.sv
// fft8_frame_loader
//   Double-buffered (ping-pong) input framer in front of the 8-point FFT core.
//   Serial signed samples are grouped into 8-sample frames in arrival order.
//   One bank fills while the other is held for the FFT.
//
// Ports
//   clk             clock; all state updates on the rising edge
//   rst             synchronous, active-high reset
//   in_data         input sample (DATA_W bits, two's complement)
//   in_valid        in_data is valid this cycle
//   in_ready        framer can accept a sample this cycle
//   frame_valid     a complete frame is presented on smp0..smp7
//   frame_ready     downstream consumes the presented frame this cycle
//   smp0..smp7      frame samples in arrival order (smp0 = first sample)
//   frame_cnt       number of frames consumed, modulo 256
//   dbg_bank_state  per-bank lifecycle state: [1:0] bank A, [3:2] bank B
//                   (0 = EMPTY, 1 = FILLING, 2 = FULL)
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. ready never depends on valid in this block (both in_ready and
// frame_valid come from registered state only); valid-side data may change
// freely while ready is low and is not sampled.

module fft8_frame_loader #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic [DATA_W-1:0] smp0,
  output logic [DATA_W-1:0] smp1,
  output logic [DATA_W-1:0] smp2,
  output logic [DATA_W-1:0] smp3,
  output logic [DATA_W-1:0] smp4,
  output logic [DATA_W-1:0] smp5,
  output logic [DATA_W-1:0] smp6,
  output logic [DATA_W-1:0] smp7,
  output logic [7:0]        frame_cnt,
  output logic [3:0]        dbg_bank_state
);

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_e;

  // Control state
  logic [1:0] full_q,      full_nxt;
  logic       wr_bank_q,   wr_bank_nxt;
  logic       rd_bank_q,   rd_bank_nxt;
  logic [2:0] wr_idx_q,    wr_idx_nxt;
  logic [7:0] frame_cnt_q, frame_cnt_nxt;

  // Sample storage: bank_mem[bank][slot]
  logic [DATA_W-1:0] bank_mem [2][8];

  logic        accept;
  logic        consume;
  bank_state_e bank_state [2];

  // Handshake events, from registered state plus the partner's valid/ready.
  assign accept  = in_valid && !full_q[wr_bank_q];
  assign consume = frame_ready && full_q[rd_bank_q];

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q      <= 2'b00;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_idx_q    <= 3'd0;
      frame_cnt_q <= 8'd0;
    end else begin
      full_q      <= full_nxt;
      wr_bank_q   <= wr_bank_nxt;
      rd_bank_q   <= rd_bank_nxt;
      wr_idx_q    <= wr_idx_nxt;
      frame_cnt_q <= frame_cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  // accept needs the fill bank not full and consume needs the present bank
  // full, so when both fire they always touch different banks and the two
  // updates to full_nxt never collide.
  always_comb begin
    full_nxt      = full_q;
    wr_bank_nxt   = wr_bank_q;
    rd_bank_nxt   = rd_bank_q;
    wr_idx_nxt    = wr_idx_q;
    frame_cnt_nxt = frame_cnt_q;

    if (consume) begin
      full_nxt[rd_bank_q] = 1'b0;
      rd_bank_nxt         = ~rd_bank_q;
      frame_cnt_nxt       = frame_cnt_q + 8'd1;
    end

    if (accept) begin
      wr_idx_nxt = wr_idx_q + 3'd1;
      if (wr_idx_q == 3'd7) begin
        full_nxt[wr_bank_q] = 1'b1;
        wr_bank_nxt         = ~wr_bank_q;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------
  always_comb begin
    in_ready    = !full_q[wr_bank_q];
    frame_valid = full_q[rd_bank_q];
    frame_cnt   = frame_cnt_q;
    smp0        = bank_mem[rd_bank_q][0];
    smp1        = bank_mem[rd_bank_q][1];
    smp2        = bank_mem[rd_bank_q][2];
    smp3        = bank_mem[rd_bank_q][3];
    smp4        = bank_mem[rd_bank_q][4];
    smp5        = bank_mem[rd_bank_q][5];
    smp6        = bank_mem[rd_bank_q][6];
    smp7        = bank_mem[rd_bank_q][7];

    // A bank is FILLING only while it is the fill target and has at least
    // one sample in it; after reset or a completed fill, wr_idx is 0.
    for (int b = 0; b < 2; b++) begin
      bank_state[b] = BANK_EMPTY;
      if (full_q[b]) begin
        bank_state[b] = BANK_FULL;
      end else if ((wr_bank_q == b[0]) && (wr_idx_q != 3'd0)) begin
        bank_state[b] = BANK_FILLING;
      end
    end
    dbg_bank_state = {bank_state[1], bank_state[0]};
  end

  // ---------------------------------------------------------------------
  // Sample storage. A FULL bank is never the write target because accept
  // is gated by the full flag of wr_bank.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int s = 0; s < 8; s++) begin
          bank_mem[b][s] <= '0;
        end
      end
    end else if (accept) begin
      bank_mem[wr_bank_q][wr_idx_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_fft8_frame_loader.sv
// Self-checking bench for fft8_frame_loader. The reference model keeps the
// frames awaiting consumption in a queue (at most two) and the partially
// received frame in a second queue; handshake outputs follow from their
// sizes.

module tb_fft8_frame_loader;

  localparam int DATA_W = 16;
  localparam int FW     = 8 * DATA_W;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              frame_valid;
  logic              frame_ready;
  logic [DATA_W-1:0] smp0, smp1, smp2, smp3, smp4, smp5, smp6, smp7;
  logic [7:0]        frame_cnt;
  logic [3:0]        dbg_bank_state;

  fft8_frame_loader #(.DATA_W(DATA_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .frame_valid    (frame_valid),
    .frame_ready    (frame_ready),
    .smp0           (smp0),
    .smp1           (smp1),
    .smp2           (smp2),
    .smp3           (smp3),
    .smp4           (smp4),
    .smp5           (smp5),
    .smp6           (smp6),
    .smp7           (smp7),
    .frame_cnt      (frame_cnt),
    .dbg_bank_state (dbg_bank_state)
  );

  // ---------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------
  // Scoreboard / reference model
  // ---------------------------------------------------------------------
  logic [FW-1:0]     exp_q[$];   // complete frames awaiting consumption
  logic [DATA_W-1:0] part_q[$];  // samples of the frame being received
  logic [7:0]        exp_cnt;
  logic              last_acc;
  int                chk_cnt;
  int                err_cnt;

  task automatic check(input string tag, input logic [FW-1:0] got,
                       input logic [FW-1:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    part_q.delete();
    exp_cnt = 8'd0;
  endtask

  function automatic logic [FW-1:0] dut_frame();
    return {smp7, smp6, smp5, smp4, smp3, smp2, smp1, smp0};
  endfunction

  // ---------------------------------------------------------------------
  // Driver tasks. Inputs are set and outputs checked at the falling edge;
  // one call of step() advances one rising edge.
  // ---------------------------------------------------------------------
  task automatic set_fr(input int fr_mode);
    if (fr_mode == 2) frame_ready = 1'($urandom_range(0, 1));
    else              frame_ready = (fr_mode == 1);
  endtask

  task automatic step();
    logic          exp_ready;
    logic          exp_valid;
    logic          con;
    logic [FW-1:0] vec;
    exp_ready = (exp_q.size() < 2);
    exp_valid = (exp_q.size() > 0);
    check("in_ready", FW'(in_ready), FW'(exp_ready));
    check("frame_valid", FW'(frame_valid), FW'(exp_valid));
    check("frame_cnt", FW'(frame_cnt), FW'(exp_cnt));
    if (exp_valid) check("frame_data", dut_frame(), exp_q[0]);
    last_acc = in_valid && exp_ready;
    con      = frame_ready && exp_valid;
    @(posedge clk);
    if (con) begin
      void'(exp_q.pop_front());
      exp_cnt = exp_cnt + 8'd1;
    end
    if (last_acc) begin
      part_q.push_back(in_data);
      if (part_q.size() == 8) begin
        vec = '0;
        for (int i = 0; i < 8; i++) vec[i*DATA_W +: DATA_W] = part_q[i];
        exp_q.push_back(vec);
        part_q.delete();
      end
    end
    @(negedge clk);
  endtask

  // Present one sample, holding it until it is accepted (bounded wait).
  task automatic send(input logic [DATA_W-1:0] v, input int gap,
                      input int fr_mode);
    int tries;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      in_data  = DATA_W'($urandom);
      set_fr(fr_mode);
      step();
    end
    in_valid = 1'b1;
    in_data  = v;
    tries    = 0;
    do begin
      set_fr(fr_mode);
      step();
      tries++;
    end while (!last_acc && tries < 200);
    check("accept_wait", FW'(last_acc), FW'(1'b1));
  endtask

  task automatic idle(input int n, input int fr_mode);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_data = DATA_W'($urandom);
      set_fr(fr_mode);
      step();
    end
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    in_valid    = 1'b1;
    in_data     = DATA_W'($urandom);
    frame_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    frame_ready = 1'b0;
    model_reset();
    check("reset_smp", dut_frame(), '0);
    check("reset_dbg", FW'(dbg_bank_state), '0);
  endtask

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] extremes [8];

  initial begin
    chk_cnt     = 0;
    err_cnt     = 0;
    last_acc    = 1'b0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_data     = '0;
    frame_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_smp", dut_frame(), '0);

    // Single frame 1..8, frame_ready high.
    for (int i = 1; i <= 8; i++) send(DATA_W'(i), 0, 1);
    idle(3, 1);

    // Continuous 1..32 with frame_ready high.
    for (int i = 1; i <= 32; i++) send(DATA_W'(i), 0, 1);
    idle(3, 1);

    // Back-pressure: 16 fill both banks, 17 stalls, one-cycle consume.
    for (int i = 1; i <= 16; i++) send(DATA_W'(i), 0, 0);
    in_valid = 1'b1;
    in_data  = DATA_W'(17);
    for (int i = 0; i < 4; i++) begin
      set_fr(0);
      step();
    end
    set_fr(1);
    step();
    for (int i = 17; i <= 20; i++) send(DATA_W'(i), 0, 0);
    idle(4, 0);
    for (int i = 21; i <= 24; i++) send(DATA_W'(i), 0, 0);
    idle(4, 0);
    idle(6, 1);

    // Extreme values, bit-exact.
    extremes[0] = 16'h8000; extremes[1] = 16'h7FFF;
    extremes[2] = 16'hFFFF; extremes[3] = 16'h0001;
    extremes[4] = 16'h8001; extremes[5] = 16'h7FFE;
    extremes[6] = 16'h0000; extremes[7] = 16'hFFFE;
    for (int i = 0; i < 8; i++) send(extremes[i], 0, 0);
    idle(2, 0);
    idle(3, 1);

    // Reset after 5 samples of a frame while the other bank is full.
    for (int i = 0; i < 13; i++) send(DATA_W'(100 + i), 0, 0);
    do_reset();
    for (int i = 0; i < 8; i++) send(DATA_W'(200 + i), 0, 0);
    idle(2, 1);

    // Gapped input, values 10..80, randomized frame_ready.
    for (int r = 0; r < 3; r++)
      for (int i = 1; i <= 8; i++) send(DATA_W'(10 * i), 2, 2);
    idle(20, 2);
    idle(4, 1);

    // Random data, random gaps, random frame_ready.
    for (int i = 0; i < 300; i++)
      send(DATA_W'($urandom), $urandom_range(0, 2), 2);
    idle(20, 1);

    // Enough consumed frames to wrap frame_cnt past 255.
    for (int i = 0; i < 260 * 8; i++) send(DATA_W'($urandom), 0, 1);
    idle(4, 1);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
